// File: rtl/debounce_bank_if.sv
// debounce_bank_if
//   Bundles the per-channel data signals of debounce_bank.
//   sample_en : sampling tick qualifier (driven by the master)
//   din       : raw asynchronous pad inputs, one bit per channel (master)
//   level     : debounced level (slave)
//   rise/fall : single-cycle pulses on an accepted 0->1 / 1->0 change (slave)
//   rep       : single-cycle press/auto-repeat pulse (slave)
//
// Handshake: there is no valid/ready pair on this bus. sample_en is a pure
// qualifier sampled on every clk edge. The outputs are registered and every
// pulse is exactly one clk wide, so a consumer never needs to back-pressure.
interface debounce_bank_if #(
  parameter int CHANNELS = 9
);
  logic                sample_en;
  logic [CHANNELS-1:0] din;
  logic [CHANNELS-1:0] level;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] rep;

  modport master (
    output sample_en, din,
    input  level, rise, fall, rep
  );

  modport slave (
    input  sample_en, din,
    output level, rise, fall, rep
  );
endinterface

// File: rtl/debounce_bank.sv
// debounce_bank
//   Multi-channel debouncer for front-panel buttons and switches. Each raw
//   input is synchronised through two flops, then a change of level is only
//   accepted after STABLE_CYCLES consecutive sample ticks that disagree with
//   the current debounced level. Accepted changes produce one-cycle rise/fall
//   pulses. Channels selected by REPEAT_MASK also produce a typematic repeat
//   pulse on rep while held; on the other channels rep is a copy of rise.
//
// Ports
//   clk     : system clock
//   reset   : synchronous, active-high; clears every register
//   io_bus  : debounce_bank_if.slave (sample_en, din in; level, rise, fall,
//             rep out). All outputs are registered.
module debounce_bank #(
  parameter int                  CHANNELS      = 9,
  parameter int                  STABLE_CYCLES = 6,
  parameter logic [CHANNELS-1:0] REPEAT_MASK   = '0,
  parameter int                  REPEAT_DELAY  = 500,
  parameter int                  REPEAT_RATE   = 100
) (
  input  logic                   clk,
  input  logic                   reset,
  debounce_bank_if.slave         io_bus
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CHANNELS-1:0] w_level;
  logic [CHANNELS-1:0] w_rise;
  logic [CHANNELS-1:0] w_fall;
  logic [CHANNELS-1:0] w_rep;

  // The synchroniser runs every clk regardless of sample_en.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= io_bus.din;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;
    logic          r_fall;
    logic          w_mismatch;
    logic          w_accept;

    assign w_mismatch = r_sync2[g] ^ r_level;
    // The final mismatching sample toggles level instead of counting.
    assign w_accept   = io_bus.sample_en && w_mismatch &&
                        (r_cnt == CW'(STABLE_CYCLES - 1));

    always_ff @(posedge clk) begin
      if (reset) begin
        r_cnt   <= '0;
        r_level <= 1'b0;
        r_rise  <= 1'b0;
        r_fall  <= 1'b0;
      end else begin
        r_rise <= w_accept & ~r_level;
        r_fall <= w_accept &  r_level;
        if (io_bus.sample_en) begin
          if (!w_mismatch) begin
            r_cnt <= '0;
          end else if (w_accept) begin
            r_cnt   <= '0;
            r_level <= ~r_level;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
      end
    end

    assign w_level[g] = r_level;
    assign w_rise[g]  = r_rise;
    assign w_fall[g]  = r_fall;

    if (REPEAT_MASK[g]) begin : g_rep
      logic [15:0] r_rcnt;
      logic        r_armed;
      logic        r_rep;
      logic [15:0] w_target;

      // Before the first repeat the interval is the long delay, afterwards
      // the shorter repeat rate.
      assign w_target = r_armed ? 16'(REPEAT_RATE) : 16'(REPEAT_DELAY);

      always_ff @(posedge clk) begin
        if (reset) begin
          r_rcnt  <= '0;
          r_armed <= 1'b0;
          r_rep   <= 1'b0;
        end else begin
          r_rep <= 1'b0;
          if (w_accept) begin
            // Press pulses immediately; a release just stops repeating.
            r_rcnt  <= '0;
            r_armed <= 1'b0;
            r_rep   <= ~r_level;
          end else if (!r_level) begin
            r_rcnt  <= '0;
            r_armed <= 1'b0;
          end else if (io_bus.sample_en) begin
            if (r_rcnt + 16'd1 == w_target) begin
              r_rep   <= 1'b1;
              r_rcnt  <= '0;
              r_armed <= 1'b1;
            end else begin
              r_rcnt <= r_rcnt + 16'd1;
            end
          end
        end
      end

      assign w_rep[g] = r_rep;
    end else begin : g_norep
      assign w_rep[g] = r_rise;
    end
  end

  assign io_bus.level = w_level;
  assign io_bus.rise  = w_rise;
  assign io_bus.fall  = w_fall;
  assign io_bus.rep   = w_rep;

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank
//   Drives three debounce_bank instances from the same din/sample_en/reset:
//     a : STABLE_CYCLES=6, no repeat channels (defaults)
//     b : STABLE_CYCLES=6, REPEAT_MASK=0x003, DELAY=4, RATE=2
//     c : STABLE_CYCLES=1, REPEAT_MASK=0x1FF, DELAY=1, RATE=1
//   A behavioural model computes the expected outputs of all three from the
//   input history; scenario tasks add targeted edge-timing checks.
module tb_debounce_bank;
  localparam int NC = 9;
  localparam int CFG_S [3] = '{6, 6, 1};
  localparam int CFG_D [3] = '{500, 4, 1};
  localparam int CFG_R [3] = '{100, 2, 1};
  localparam logic [NC-1:0] CFG_M [3] = '{9'h000, 9'h003, 9'h1FF};

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_en = 1'b0;
  logic [NC-1:0] din = '0;
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [15:0]   exp_q [$];

  // clock / reset block
  always #5 clk = ~clk;

  debounce_bank_if #(.CHANNELS(NC)) if_a ();
  debounce_bank_if #(.CHANNELS(NC)) if_b ();
  debounce_bank_if #(.CHANNELS(NC)) if_c ();

  assign if_a.sample_en = sample_en;
  assign if_b.sample_en = sample_en;
  assign if_c.sample_en = sample_en;
  assign if_a.din = din;
  assign if_b.din = din;
  assign if_c.din = din;

  debounce_bank #(.CHANNELS(NC), .STABLE_CYCLES(6), .REPEAT_MASK(9'h000),
                  .REPEAT_DELAY(500), .REPEAT_RATE(100))
    dut_a (.clk(clk), .reset(reset), .io_bus(if_a));
  debounce_bank #(.CHANNELS(NC), .STABLE_CYCLES(6), .REPEAT_MASK(9'h003),
                  .REPEAT_DELAY(4), .REPEAT_RATE(2))
    dut_b (.clk(clk), .reset(reset), .io_bus(if_b));
  debounce_bank #(.CHANNELS(NC), .STABLE_CYCLES(1), .REPEAT_MASK(9'h1FF),
                  .REPEAT_DELAY(1), .REPEAT_RATE(1))
    dut_c (.clk(clk), .reset(reset), .io_bus(if_c));

  // ---------------- reference model ----------------
  // The input reaches the decision logic two edges after it is applied.
  // A change is accepted once STABLE_CYCLES consecutive ticks disagree with
  // the level. Repeats fire at tick DELAY after the press and every RATE
  // ticks after that.
  logic [NC-1:0] m_level [3];
  logic [NC-1:0] m_rise  [3];
  logic [NC-1:0] m_fall  [3];
  logic [NC-1:0] m_rep   [3];
  int            m_run   [3][NC];
  int            m_t     [3][NC];
  logic [NC-1:0] m_h1, m_h2, m_s;

  always @(posedge clk) begin
    if (reset) begin
      m_h1 = '0;
      m_h2 = '0;
      for (int k = 0; k < 3; k++) begin
        m_level[k] = '0; m_rise[k] = '0; m_fall[k] = '0; m_rep[k] = '0;
        for (int ch = 0; ch < NC; ch++) begin
          m_run[k][ch] = 0;
          m_t[k][ch]   = 0;
        end
      end
    end else begin
      m_s  = m_h2;
      m_h2 = m_h1;
      m_h1 = din;
      for (int k = 0; k < 3; k++) begin
        for (int ch = 0; ch < NC; ch++) begin
          m_rise[k][ch] = 1'b0;
          m_fall[k][ch] = 1'b0;
          m_rep[k][ch]  = 1'b0;
          if (sample_en) begin
            if (m_s[ch] == m_level[k][ch]) begin
              m_run[k][ch] = 0;
            end else begin
              m_run[k][ch]++;
              if (m_run[k][ch] == CFG_S[k]) begin
                m_run[k][ch] = 0;
                if (m_level[k][ch]) m_fall[k][ch] = 1'b1;
                else                m_rise[k][ch] = 1'b1;
                m_level[k][ch] = ~m_level[k][ch];
              end
            end
          end
          if (!CFG_M[k][ch]) begin
            m_rep[k][ch] = m_rise[k][ch];
          end else if (m_rise[k][ch]) begin
            m_t[k][ch]   = 0;
            m_rep[k][ch] = 1'b1;
          end else if (m_fall[k][ch] || !m_level[k][ch]) begin
            m_t[k][ch] = 0;
          end else if (sample_en) begin
            m_t[k][ch]++;
            if (m_t[k][ch] == CFG_D[k] ||
                (m_t[k][ch] > CFG_D[k] && (m_t[k][ch] - CFG_D[k]) % CFG_R[k] == 0))
              m_rep[k][ch] = 1'b1;
          end
        end
      end
    end
  end

  logic [12*NC-1:0] obs_v, exp_v;
  assign obs_v = {if_a.level, if_a.rise, if_a.fall, if_a.rep,
                  if_b.level, if_b.rise, if_b.fall, if_b.rep,
                  if_c.level, if_c.rise, if_c.fall, if_c.rep};
  assign exp_v = {m_level[0], m_rise[0], m_fall[0], m_rep[0],
                  m_level[1], m_rise[1], m_fall[1], m_rep[1],
                  m_level[2], m_rise[2], m_fall[2], m_rep[2]};

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [NC-1:0] el, er;
    reset = 1'b1; sample_en = 1'b1; din = '1;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== '0) begin
        n_bad++; $display("FAIL reset_outputs obs=%h exp=0", obs_v);
      end
    end
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++; $display("FAIL reset_model t=%0t obs=%h exp=%h", $time, obs_v, exp_v);
      end
      el = (i >= 8) ? '1 : '0;
      er = (i == 8) ? '1 : '0;
      n_cmp++;
      if ({if_a.level, if_a.rise} !== {el, er}) begin
        n_bad++;
        $display("FAIL reset_release_edge%0d level=%h rise=%h exp_level=%h exp_rise=%h",
                 i, if_a.level, if_a.rise, el, er);
      end
    end
  endtask

  task automatic test_bounce();
    int n_rise, n_fall, rise_edge;
    din = '0; sample_en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++; $display("FAIL bounce_settle t=%0t obs=%h exp=%h", $time, obs_v, exp_v);
      end
    end
    n_rise = 0; n_fall = 0; rise_edge = -1;
    for (int p = 0; p < 4; p++) begin
      din[0] = (p % 2 == 0);
      repeat (2) begin
        @(negedge clk);
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_bad++; $display("FAIL bounce_model t=%0t obs=%h exp=%h", $time, obs_v, exp_v);
        end
        n_rise += int'(if_a.rise[0]);
        n_fall += int'(if_a.fall[0]);
      end
    end
    din[0] = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++; $display("FAIL bounce_model t=%0t obs=%h exp=%h", $time, obs_v, exp_v);
      end
      if (if_a.rise[0]) begin n_rise++; rise_edge = i; end
      n_fall += int'(if_a.fall[0]);
    end
    n_cmp++;
    if (n_rise != 1 || rise_edge != 8 || n_fall != 0) begin
      n_bad++;
      $display("FAIL bounce_single_rise rises=%0d at_edge=%0d falls=%0d exp 1/8/0",
               n_rise, rise_edge, n_fall);
    end
  endtask

  task automatic test_glitch();
    int n_act;
    din = '0; sample_en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++; $display("FAIL glitch_settle t=%0t obs=%h exp=%h", $time, obs_v, exp_v);
      end
    end
    n_act = 0;
    for (int i = 0; i < 25; i++) begin
      din[3] = (i < 5);
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++; $display("FAIL glitch_model t=%0t obs=%h exp=%h", $time, obs_v, exp_v);
      end
      n_act += int'(if_a.level[3] | if_a.rise[3] | if_a.fall[3] | if_a.rep[3]);
    end
    n_cmp++;
    if (n_act != 0) begin
      n_bad++; $display("FAIL glitch_ignored active_cycles=%0d exp=0", n_act);
    end
  endtask

  task automatic test_sample_en();
    logic [NC-1:0] lv_prev;
    logic          se_prev;
    int            rise_edge;
    din = '0; sample_en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++; $display("FAIL tick_settle t=%0t obs=%h exp=%h", $time, obs_v, exp_v);
      end
    end
    rise_edge = -1;
    for (int c = 0; c < 48; c++) begin
      sample_en = (c % 4 == 0);
      if (c == 2) din[1] = 1'b1;
      lv_prev = if_a.level;
      se_prev = sample_en;
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++; $display("FAIL tick_model t=%0t obs=%h exp=%h", $time, obs_v, exp_v);
      end
      if (!se_prev) begin
        n_cmp++;
        if (if_a.level !== lv_prev) begin
          n_bad++; $display("FAIL tick_hold c=%0d level=%h exp=%h", c, if_a.level, lv_prev);
        end
      end
      if (if_a.rise[1]) rise_edge = c;
    end
    n_cmp++;
    if (rise_edge != 24) begin
      n_bad++; $display("FAIL tick_latency rise_edge=%0d exp=24", rise_edge);
    end
    sample_en = 1'b1;
  endtask

  task automatic test_repeat();
    logic exp_bit;
    int   n_rep5;
    din = '0; sample_en = 1'b1;
    repeat (20) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++; $display("FAIL repeat_settle t=%0t obs=%h exp=%h", $time, obs_v, exp_v);
      end
    end
    n_rep5 = 0;
    // phase 0: first press, phase 1: release, phase 2: second press
    for (int ph = 0; ph < 3; ph++) begin
      exp_q.delete();
      if (ph == 0) exp_q = '{16'd0, 16'd4, 16'd6, 16'd8, 16'd10, 16'd12};
      if (ph == 2) exp_q = '{16'd0, 16'd4, 16'd6};
      din[0] = (ph != 1);
      if (ph == 0) din[5] = 1'b1;
      for (int i = 1; i <= ((ph == 2) ? 14 : 20); i++) begin
        @(negedge clk);
        n_cmp++;
        if (obs_v !== exp_v) begin
          n_bad++; $display("FAIL repeat_model t=%0t obs=%h exp=%h", $time, obs_v, exp_v);
        end
        n_rep5 += int'(if_b.rep[5]);
        if (i == 8) begin
          n_cmp++;
          if (if_b.rise[0] !== (ph != 1) || if_b.fall[0] !== (ph == 1)) begin
            n_bad++;
            $display("FAIL repeat_edge ph=%0d rise=%b fall=%b", ph, if_b.rise[0], if_b.fall[0]);
          end
        end
        if (i >= 8 && ph != 1) begin
          exp_bit = (exp_q.size() > 0 && exp_q[0] == 16'(i - 8));
          if (exp_bit) void'(exp_q.pop_front());
          n_cmp++;
          if (if_b.rep[0] !== exp_bit) begin
            n_bad++;
            $display("FAIL repeat_timing ph=%0d off=%0d rep=%b exp=%b", ph, i - 8, if_b.rep[0], exp_bit);
          end
        end
        if (i > 8 && ph == 1) begin
          n_cmp++;
          if (if_b.rep[0] !== 1'b0) begin
            n_bad++; $display("FAIL repeat_stop off=%0d rep=1 exp=0", i - 8);
          end
        end
      end
    end
    n_cmp++;
    if (n_rep5 != 1) begin
      n_bad++; $display("FAIL repeat_nomask_ch5 pulses=%0d exp=1", n_rep5);
    end
  endtask

  task automatic test_reset_mid();
    int n_fall;
    // ch0/ch5 are held from the repeat test; start new counts on ch2/ch4
    din[2] = 1'b1; din[4] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++; $display("FAIL midreset_pre t=%0t obs=%h exp=%h", $time, obs_v, exp_v);
      end
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== '0) begin
        n_bad++; $display("FAIL midreset_clear obs=%h exp=0", obs_v);
      end
    end
    reset = 1'b0;
    n_fall = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++; $display("FAIL midreset_model t=%0t obs=%h exp=%h", $time, obs_v, exp_v);
      end
      n_fall += int'(|{if_a.fall, if_b.fall, if_c.fall});
      if (i == 8) begin
        n_cmp++;
        if (if_a.level !== din || if_a.rise !== din) begin
          n_bad++;
          $display("FAIL midreset_fresh_rise level=%h rise=%h exp=%h", if_a.level, if_a.rise, din);
        end
      end
    end
    n_cmp++;
    if (n_fall != 0) begin
      n_bad++; $display("FAIL midreset_no_fall falls=%0d exp=0", n_fall);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < NC; ch++)
        if ($urandom_range(0, 11) == 0) din[ch] = ~din[ch];
      sample_en = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_bad++; $display("FAIL random_model t=%0t obs=%h exp=%h", $time, obs_v, exp_v);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_glitch();
    test_sample_en();
    test_repeat();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
